// File: rtl/rf_mp.sv
// Multi-port integer register file: combinational reads with optional write bypass,
// per-register pending scoreboard and a registered multi-port write-collision flag.
module rf_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 1,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  output logic                wr_collision_o
);

  // Storage index width; AW may be wider (e.g. RV32E behind 5-bit decode fields).
  localparam int unsigned IW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] sb_q, sb_d;
  logic             coll_q, coll_d;
  logic [NWR-1:0]   wr_ok;
  logic [AW-1:0]    rd_a;
  logic             rd_hit;

  // Non-zero and inside the implemented register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREGS);
  endfunction

  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_ok[j] = wr_en_i[j] && addr_ok(wr_addr_i[j*AW +: AW]);
    end
  end

  // Higher-index write port wins by being applied last; set is applied after clears.
  always_comb begin
    regs_d = regs_q;
    sb_d   = sb_q;
    coll_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) begin
        regs_d[wr_addr_i[j*AW +: IW]] = wr_data_i[j*XLEN +: XLEN];
        sb_d[wr_addr_i[j*AW +: IW]]   = 1'b0;
        for (int k = j + 1; k < NWR; k++) begin
          if (wr_ok[k] && (wr_addr_i[k*AW +: AW] == wr_addr_i[j*AW +: AW])) coll_d = 1'b1;
        end
      end
    end
    if (sb_set_i && addr_ok(sb_addr_i)) sb_d[sb_addr_i[IW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      sb_q   <= '0;
      coll_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
      coll_q <= coll_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_a      = '0;
    rd_hit    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_a   = rd_addr_i[i*AW +: AW];
      rd_hit = 1'b0;
      if (addr_ok(rd_a)) begin
        rd_data_o[i*XLEN +: XLEN] = regs_q[rd_a[IW-1:0]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wr_addr_i[j*AW +: AW] == rd_a)) begin
            rd_hit = 1'b1;
            if (BYPASS != 0) rd_data_o[i*XLEN +: XLEN] = wr_data_i[j*XLEN +: XLEN];
          end
        end
        rd_busy_o[i] = sb_q[rd_a[IW-1:0]] && !((BYPASS != 0) && rd_hit);
      end
    end
  end

  assign wr_collision_o = coll_q;

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: a bypassing 32-reg dual-write instance (a) and a
// non-bypassing 16-reg RV32E instance with 5-bit addresses (b).
module tb_rf_mp;
  logic clk, rst_n;
  int   checks, errors;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_sb_set;
  logic [4:0]  a_sb_addr;
  logic        a_coll;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_sb_set;
  logic [4:0]  b_sb_addr;
  logic        b_coll;

  rf_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
    .rd_busy_o(a_rd_busy), .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .sb_set_i(a_sb_set), .sb_addr_i(a_sb_addr), .wr_collision_o(a_coll)
  );

  rf_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(1), .BYPASS(0), .AW(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
    .rd_busy_o(b_rd_busy), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .sb_set_i(b_sb_set), .sb_addr_i(b_sb_addr), .wr_collision_o(b_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic idle();
    a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_sb_set = 1'b0; a_sb_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_sb_set = 1'b0; b_sb_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); a_rd_addr = {5'd2, 5'd1}; b_rd_addr = {5'd2, 5'd1};
    #1;
    checks++; if (a_rd_data[31:0] !== 32'h0) begin
      $display("FAIL reset_a_x1 got %h want 0", a_rd_data[31:0]); errors++; end
    checks++; if (a_rd_busy !== 2'b00 || a_coll !== 1'b0) begin
      $display("FAIL reset_a_flags got busy=%b coll=%b want 00/0", a_rd_busy, a_coll); errors++; end
    checks++; if (b_rd_data[31:0] !== 32'h0) begin
      $display("FAIL reset_b_x1 got %h want 0", b_rd_data[31:0]); errors++; end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'(i)}; a_wr_data = {32'h0, 32'(i)};
      b_wr_en = (i < 16) ? 1'b1 : 1'b0; b_wr_addr = 5'(i); b_wr_data = 32'(i) + 32'h100;
    end
    @(negedge clk); idle();
    a_rd_addr = {5'd1, 5'd31}; b_rd_addr = {5'd0, 5'd15};
    #1;
    checks++; if (a_rd_data !== {32'd1, 32'd31}) begin
      $display("FAIL fill_a got %h want %h", a_rd_data, {32'd1, 32'd31}); errors++; end
    checks++; if (b_rd_data[31:0] !== 32'h10F) begin
      $display("FAIL fill_b got %h want 0000010f", b_rd_data[31:0]); errors++; end
    @(posedge clk); #3; rst_n = 1'b0; #1;
    checks++; if (a_rd_data !== 64'h0) begin
      $display("FAIL midcycle_reset_a got %h want 0", a_rd_data); errors++; end
    checks++; if (b_rd_data[31:0] !== 32'h0) begin
      $display("FAIL midcycle_reset_b got %h want 0", b_rd_data[31:0]); errors++; end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk); idle();
    a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'h11};
    b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_data = 32'h11;
    @(negedge clk);
    a_wr_data = {32'h0, 32'hDEADBEEF}; b_wr_data = 32'hDEADBEEF;
    a_rd_addr = {5'd0, 5'd5}; b_rd_addr = {5'd0, 5'd5};
    #1;
    checks++; if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL bypass_on got %h want deadbeef", a_rd_data[31:0]); errors++; end
    checks++; if (b_rd_data[31:0] !== 32'h11) begin
      $display("FAIL bypass_off got %h want 00000011", b_rd_data[31:0]); errors++; end
    @(negedge clk); idle(); #1;
    checks++; if (a_rd_data[31:0] !== 32'hDEADBEEF || b_rd_data[31:0] !== 32'hDEADBEEF) begin
      $display("FAIL write_x5 got a=%h b=%h want deadbeef", a_rd_data[31:0], b_rd_data[31:0]);
      errors++; end
  endtask

  task automatic test_x0();
    @(negedge clk); idle();
    a_wr_en = 2'b01; a_wr_addr = '0; a_wr_data = {32'h0, 32'h1234}; a_sb_set = 1'b1;
    b_wr_en = 1'b1; b_wr_addr = '0; b_wr_data = 32'h1234; b_sb_set = 1'b1;
    a_rd_addr = '0; b_rd_addr = '0;
    #1;
    checks++; if (a_rd_data[31:0] !== 32'h0 || a_rd_busy[0] !== 1'b0) begin
      $display("FAIL x0_bypass got %h busy=%b want 0/0", a_rd_data[31:0], a_rd_busy[0]); errors++; end
    @(negedge clk); idle(); #1;
    checks++; if (a_rd_data[31:0] !== 32'h0 || a_rd_busy[0] !== 1'b0) begin
      $display("FAIL x0_a got %h busy=%b want 0/0", a_rd_data[31:0], a_rd_busy[0]); errors++; end
    checks++; if (b_rd_data[31:0] !== 32'h0 || b_rd_busy[0] !== 1'b0) begin
      $display("FAIL x0_b got %h busy=%b want 0/0", b_rd_data[31:0], b_rd_busy[0]); errors++; end
  endtask

  task automatic test_collision();
    @(negedge clk); idle();
    a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'hB, 32'hA}; a_rd_addr = {5'd0, 5'd7};
    #1;
    checks++; if (a_rd_data[31:0] !== 32'hB) begin
      $display("FAIL coll_bypass got %h want 0000000b", a_rd_data[31:0]); errors++; end
    @(negedge clk); idle(); #1;
    checks++; if (a_rd_data[31:0] !== 32'hB) begin
      $display("FAIL coll_x7 got %h want 0000000b", a_rd_data[31:0]); errors++; end
    checks++; if (a_coll !== 1'b1) begin
      $display("FAIL coll_pulse got %b want 1", a_coll); errors++; end
    @(negedge clk); #1;
    checks++; if (a_coll !== 1'b0) begin
      $display("FAIL coll_clear got %b want 0", a_coll); errors++; end
    @(negedge clk);
    a_wr_en = 2'b11; a_wr_addr = {5'd8, 5'd9}; a_wr_data = {32'h8, 32'h9};
    @(negedge clk); idle(); #1;
    checks++; if (a_coll !== 1'b0) begin
      $display("FAIL coll_distinct got %b want 0", a_coll); errors++; end
  endtask

  task automatic test_scoreboard();
    logic [1:0] exp_a [5];
    logic [1:0] exp_b [5];
    exp_a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_b = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_rd_addr = {5'd0, 5'd3}; b_rd_addr = {5'd0, 5'd3};
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); idle();
      a_sb_set = (s < 2); a_sb_addr = 5'd3; b_sb_set = (s < 2); b_sb_addr = 5'd3;
      if (s == 1 || s == 3) begin
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'(s)};
        b_wr_en = 1'b1;  b_wr_addr = 5'd3; b_wr_data = 32'(s);
      end
      #1;
      checks++; if (a_rd_busy[0] !== exp_a[s][0]) begin
        $display("FAIL sb_a step %0d got %b want %b", s, a_rd_busy[0], exp_a[s][0]); errors++; end
      checks++; if (b_rd_busy[0] !== exp_b[s][0]) begin
        $display("FAIL sb_b step %0d got %b want %b", s, b_rd_busy[0], exp_b[s][0]); errors++; end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_out_of_range();
    @(negedge clk); idle();
    b_wr_en = 1'b1; b_wr_addr = 5'd4; b_wr_data = 32'h44;
    @(negedge clk);
    b_wr_addr = 5'd20; b_wr_data = 32'hFF; b_sb_set = 1'b1; b_sb_addr = 5'd20;
    b_rd_addr = {5'd4, 5'd20};
    #1;
    checks++; if (b_rd_data !== {32'h44, 32'h0} || b_rd_busy !== 2'b00) begin
      $display("FAIL oor_during got %h busy=%b want %h/00", b_rd_data, b_rd_busy, {32'h44, 32'h0});
      errors++; end
    @(negedge clk); idle(); #1;
    checks++; if (b_rd_data !== {32'h44, 32'h0} || b_rd_busy !== 2'b00) begin
      $display("FAIL oor_after got %h busy=%b want %h/00", b_rd_data, b_rd_busy, {32'h44, 32'h0});
      errors++; end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_bypass();
    test_x0();
    test_collision();
    test_scoreboard();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
